// File: rtl/axi_sram_responder_if.sv
// Bus bundle between an AXI-style initiator and the SRAM responder.
// Uses the aw/w/b and ar/r channels, 32-bit data and fixed bursts, with no length fields.
//
// Handshake rule for every channel:
//   A transfer happens on a rising clock edge where both valid and ready are high.
//   Once the source raises valid, it holds valid and its payload steady until that edge.
//   The sink may raise or lower ready at any time.
interface axi_sram_responder_if;
  logic        awvalid;
  logic        awready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [5:0]  awatop;
  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        bvalid;
  logic        bready;
  logic [3:0]  bid;
  logic        bcomp;
  logic        arvalid;
  logic        arready;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic        rvalid;
  logic        rready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic        rlast;

  modport master (
    output awvalid, awid, awaddr, awatop, wvalid, wdata, wstrb, wlast, bready,
           arvalid, arid, araddr, rready,
    input  awready, wready, bvalid, bid, bcomp, arready, rvalid, rid, rdata, rlast
  );

  modport slave (
    input  awvalid, awid, awaddr, awatop, wvalid, wdata, wstrb, wlast, bready,
           arvalid, arid, araddr, rready,
    output awready, wready, bvalid, bid, bcomp, arready, rvalid, rid, rdata, rlast
  );
endinterface

// File: rtl/axi_sram_responder.sv
// SRAM-backed AXI responder with a single transaction in flight.
// Each burst moves one aligned cache line of BURST_LEN 32-bit beats.
// The beat address wraps inside the aligned line, so extra write beats overwrite it from beat 0.
// Writes take priority over reads when both address channels are valid in IDLE.
module axi_sram_responder #(
  parameter int MEM_AW    = 10,
  parameter int BURST_LEN = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  axi_sram_responder_if.slave  bus,
  output logic [2:0]           dbg_state_o
);
  localparam int CW = $clog2(BURST_LEN);
  localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_LEN - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WDATA  = 3'd1,
    ST_WRESP  = 3'd2,
    ST_RFETCH = 3'd3,
    ST_RDATA  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [3:0]        id_q, id_d;
  logic [MEM_AW-1:0] base_q, base_d;
  logic              bcomp_q, bcomp_d;
  logic [31:0]       rdata_q;
  logic              mem_we;
  logic              rd_load;
  logic [MEM_AW-1:0] beat_addr;
  logic [31:0]       mem [2**MEM_AW];

  // The line-aligned part of the base comes first, then the beat counter, so accesses wrap inside the line.
  assign beat_addr   = {base_q[MEM_AW-1:CW], cnt_q};
  assign bus.bid     = id_q;
  assign bus.bcomp   = bcomp_q;
  assign bus.rid     = id_q;
  assign bus.rdata   = rdata_q;
  assign dbg_state_o = state_q;

  // Address bits outside the word index, the low base bits and the atomic op code are ignored.
  logic unused_bits;
  assign unused_bits = ^{bus.awatop, bus.awaddr[31:MEM_AW+2], bus.awaddr[1:0],
                         bus.araddr[31:MEM_AW+2], bus.araddr[1:0], base_q[CW-1:0]};

  // Next-state logic, capture logic, and channel handshake outputs.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    id_d        = id_q;
    base_d      = base_q;
    bcomp_d     = bcomp_q;
    mem_we      = 1'b0;
    rd_load     = 1'b0;
    bus.awready = 1'b0;
    bus.arready = 1'b0;
    bus.wready  = 1'b0;
    bus.bvalid  = 1'b0;
    bus.rvalid  = 1'b0;
    bus.rlast   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        bus.awready = bus.awvalid;
        bus.arready = bus.arvalid & ~bus.awvalid;
        if (bus.awvalid) begin
          id_d    = bus.awid;
          base_d  = bus.awaddr[MEM_AW+1:2];
          cnt_d   = '0;
          state_d = ST_WDATA;
        end else if (bus.arvalid) begin
          id_d    = bus.arid;
          base_d  = bus.araddr[MEM_AW+1:2];
          cnt_d   = '0;
          state_d = ST_RFETCH;
        end
      end
      ST_WDATA: begin
        bus.wready = 1'b1;
        if (bus.wvalid) begin
          mem_we = 1'b1;
          cnt_d  = cnt_q + 1'b1;
          if (bus.wlast) begin
            // A burst is well-formed only when wlast arrives on the final beat slot.
            bcomp_d = (cnt_q == LAST_BEAT);
            state_d = ST_WRESP;
          end
        end
      end
      ST_WRESP: begin
        bus.bvalid = 1'b1;
        if (bus.bready) state_d = ST_IDLE;
      end
      ST_RFETCH: begin
        rd_load = 1'b1;
        state_d = ST_RDATA;
      end
      ST_RDATA: begin
        bus.rvalid = 1'b1;
        bus.rlast  = (cnt_q == LAST_BEAT);
        if (bus.rready) begin
          if (cnt_q == LAST_BEAT) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = ST_RFETCH;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control registers and the read data holding register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      id_q    <= '0;
      base_q  <= '0;
      bcomp_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      id_q    <= id_d;
      base_q  <= base_d;
      bcomp_q <= bcomp_d;
      if (rd_load) rdata_q <= mem[beat_addr];
    end
  end

  // Byte-strobed SRAM write.
  // Contents survive reset, but a beat arriving in the reset cycle is dropped with its burst.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.wstrb[i]) mem[beat_addr][8*i +: 8] <= bus.wdata[8*i +: 8];
      end
    end
  end
endmodule
